irrigation_input_conditioner: RTL and testbench
===============================================

# irrigation_input_conditioner

Front-end stage feeding the irrigation controller: synchronizes and debounces the raw sprinkler (asp), drip (got) and fertilizer (adb) switches. It arbitrates asp/got into a single registered irrigation mode and flags simultaneous requests as a conflict. Its outputs drive the controller's asp/got/adb inputs directly, replacing raw switch wiring.

## Interface
- PRESCALE, 1024: clock cycles per debounce sample tick (≥2).
- DEB_TICKS, 4: consecutive differing sample ticks required to flip a debounced level (≥1).
- ACTIVE_LOW, 1: 1 = raw switches are active-low and are inverted after synchronization.
- clock  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- asp_raw / got_raw / adb_raw  input  1 each  asynchronous raw switch levels.
- asp  output  1  high only in mode ASP.
- got  output  1  high only in mode GOT.
- adb  output  1  debounced fertilizer level; forced 0 unless mode is ASP.
- mode  output  2  00 IDLE, 01 ASP, 10 GOT, 11 CONFLICT.
- conflict  output  1  high in mode CONFLICT.
- mode_change  output  1  one-cycle pulse on every mode transition.

## Operation
- Per input: 2-flop synchronizer, then polarity fix per ACTIVE_LOW.
- Prescaler: counts 0..PRESCALE-1 and wraps; tick = 1 for one cycle when count = PRESCALE-1.
- Debounce per channel (stable level s, counter c):
  - On tick with sync ≠ s: if c = DEB_TICKS-1, then s ← sync and c ← 0; else c ← c+1.
  - On tick with sync = s: c ← 0. Any glitch shorter than DEB_TICKS ticks is rejected.
  - Between ticks: s and c hold.
- Mode FSM, evaluated every cycle on stable levels sa, sg:
  - IDLE: sa&~sg → ASP; ~sa&sg → GOT; sa&sg → CONFLICT.
  - ASP: sg → CONFLICT; ~sa → IDLE.
  - GOT: sa → CONFLICT; ~sg → IDLE.
  - CONFLICT: only ~sa&~sg → IDLE. Releasing one switch does not fall back to the other mode.
- adb = stable adb & (mode == ASP). adb never affects the mode.
- mode_change = 1 in the cycle mode takes a new value.

## Timing
- Reset: all outputs 0, mode IDLE, prescaler 0, debounce counters 0, stable levels 0 (inactive).
- Synchronizer flops reset to the inactive raw level (1 if ACTIVE_LOW).
- Reset asserted mid-debounce or mid-mode discards all progress. After release, a held switch re-qualifies from scratch.
- Latency: a raw change held steady flips s at the DEB_TICKS-th qualifying tick after reaching the synchronizer output (2 cycles).
- Worst case raw → s is 2 + PRESCALE·DEB_TICKS cycles.
- mode, asp/got/adb, conflict and mode_change are registered and update 1 cycle after s changes.
- asp and got change simultaneously on the same tick: the FSM sees both, e.g. IDLE → CONFLICT directly, never passing through ASP.

## Configuration
- IRRIG_DEBOUNCE_BYPASS_EN defined: prescaler and debounce counters are removed, and s = synchronizer output. Raw → mode latency is 3 cycles; PRESCALE and DEB_TICKS are ignored. Intended for fast system simulation.
- Undefined: full debounce as described.

## Structure
- Shared package irrigation_pkg holds:
  - mode encodings MODE_IDLE, MODE_ASP, MODE_GOT, MODE_CONFLICT;
  - the 2-bit mode type;
  - default PRESCALE/DEB_TICKS constants.
- Sub-module debounce_channel: synchronizer, polarity fix and counter. Instantiated three times, sharing one tick input.
- Prescaler and mode FSM live in the top.

## Test plan
Bench parameters: PRESCALE=4, DEB_TICKS=3, ACTIVE_LOW=1.
- Reset held 3 cycles with all raw inputs 0 (active) → all outputs 0, mode 00. Release → asp/got still 0 until qualified.
- asp_raw 1→0 held → mode 01 and asp=1 exactly 1 cycle after the 3rd qualifying tick; mode_change pulses 1 cycle.
- got_raw low-glitch lasting 2 ticks while in ASP → no change: mode stays 01, conflict 0.
- In ASP, got_raw asserted and qualified → mode 11, conflict=1, asp=got=0. Release asp only → stays 11. Release got → 00.
- adb_raw active while mode GOT → adb=0. Switch to ASP → adb=1 the same cycle mode becomes 01.
- Reset asserted 1 cycle before asp would qualify → no mode change; asp needs 3 fresh ticks after release. Rerun with IRRIG_DEBOUNCE_BYPASS_EN → mode 01 3 cycles after asp_raw falls.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation input conditioner: mode encodings and default timing.
// Used by both default and IRRIG_DEBOUNCE_BYPASS_EN builds.
package irrigation_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'b00,
        MODE_ASP      = 2'b01,
        MODE_GOT      = 2'b10,
        MODE_CONFLICT = 2'b11
    } mode_t;

    localparam int DEFAULT_PRESCALE  = 1024;
    localparam int DEFAULT_DEB_TICKS = 4;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, polarity fix and tick-based debounce counter.
// With IRRIG_DEBOUNCE_BYPASS_EN defined the stable level is the synchronizer output.
module debounce_channel #(
    parameter int DEB_TICKS  = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic reset,
`ifndef IRRIG_DEBOUNCE_BYPASS_EN
    input  logic tick,
`endif
    input  logic raw,
    output logic stable
);

    localparam logic POL = ACTIVE_LOW;

    logic sync1_r;
    logic sync2_r;
    logic level_s;

    // Synchronizer; resets to the inactive raw level so release looks idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= POL;
            sync2_r <= POL;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    assign level_s = sync2_r ^ POL;

`ifdef IRRIG_DEBOUNCE_BYPASS_EN
    assign stable = level_s;
`else
    localparam int CNT_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    // Flip only after DEB_TICKS consecutive ticks disagree with the stable level.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (tick) begin
            if (level_s != stable_r) begin
                if (cnt_r == CNT_LAST) begin
                    stable_r <= level_s;
                    cnt_r    <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign stable = stable_r;
`endif

endmodule

// File: rtl/irrigation_input_conditioner.sv
// Conditions raw asp/got/adb switches and arbitrates asp/got into a registered irrigation mode.
// Define IRRIG_DEBOUNCE_BYPASS_EN to drop the prescaler and debounce for fast simulation.
module irrigation_input_conditioner
    import irrigation_pkg::*;
#(
    parameter int PRESCALE   = DEFAULT_PRESCALE,
    parameter int DEB_TICKS  = DEFAULT_DEB_TICKS,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       asp_raw,
    input  logic       got_raw,
    input  logic       adb_raw,
    output logic       asp,
    output logic       got,
    output logic       adb,
    output logic [1:0] mode,
    output logic       conflict,
    output logic       mode_change
);

    logic  sa_s;
    logic  sg_s;
    logic  sadb_s;
    mode_t mode_r;
    mode_t next_mode_s;
    logic  asp_r;
    logic  got_r;
    logic  adb_r;
    logic  conflict_r;
    logic  mode_change_r;

`ifndef IRRIG_DEBOUNCE_BYPASS_EN
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_cnt_r;
    logic            tick_s;

    // Free-running sample prescaler shared by all channels.
    always_ff @(posedge clock) begin
        if (reset) begin
            ps_cnt_r <= {PS_W{1'b0}};
        end else if (ps_cnt_r == PS_LAST) begin
            ps_cnt_r <= {PS_W{1'b0}};
        end else begin
            ps_cnt_r <= ps_cnt_r + 1'b1;
        end
    end

    assign tick_s = (ps_cnt_r == PS_LAST);
`endif

    debounce_channel #(.DEB_TICKS(DEB_TICKS), .ACTIVE_LOW(ACTIVE_LOW)) u_asp (
        .clock (clock),
        .reset (reset),
`ifndef IRRIG_DEBOUNCE_BYPASS_EN
        .tick  (tick_s),
`endif
        .raw   (asp_raw),
        .stable(sa_s)
    );

    debounce_channel #(.DEB_TICKS(DEB_TICKS), .ACTIVE_LOW(ACTIVE_LOW)) u_got (
        .clock (clock),
        .reset (reset),
`ifndef IRRIG_DEBOUNCE_BYPASS_EN
        .tick  (tick_s),
`endif
        .raw   (got_raw),
        .stable(sg_s)
    );

    debounce_channel #(.DEB_TICKS(DEB_TICKS), .ACTIVE_LOW(ACTIVE_LOW)) u_adb (
        .clock (clock),
        .reset (reset),
`ifndef IRRIG_DEBOUNCE_BYPASS_EN
        .tick  (tick_s),
`endif
        .raw   (adb_raw),
        .stable(sadb_s)
    );

    // Mode arbitration; CONFLICT is sticky until both switches are released.
    always_comb begin
        next_mode_s = mode_r;
        case (mode_r)
            MODE_IDLE: begin
                if (sa_s && sg_s) begin
                    next_mode_s = MODE_CONFLICT;
                end else if (sa_s) begin
                    next_mode_s = MODE_ASP;
                end else if (sg_s) begin
                    next_mode_s = MODE_GOT;
                end else begin
                    next_mode_s = MODE_IDLE;
                end
            end
            MODE_ASP: begin
                if (sg_s) begin
                    next_mode_s = MODE_CONFLICT;
                end else if (!sa_s) begin
                    next_mode_s = MODE_IDLE;
                end else begin
                    next_mode_s = MODE_ASP;
                end
            end
            MODE_GOT: begin
                if (sa_s) begin
                    next_mode_s = MODE_CONFLICT;
                end else if (!sg_s) begin
                    next_mode_s = MODE_IDLE;
                end else begin
                    next_mode_s = MODE_GOT;
                end
            end
            MODE_CONFLICT: begin
                if (!sa_s && !sg_s) begin
                    next_mode_s = MODE_IDLE;
                end else begin
                    next_mode_s = MODE_CONFLICT;
                end
            end
            default: begin
                next_mode_s = MODE_IDLE;
            end
        endcase
    end

    // Mode and decoded outputs are registered together from the next mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r        <= MODE_IDLE;
            asp_r         <= 1'b0;
            got_r         <= 1'b0;
            adb_r         <= 1'b0;
            conflict_r    <= 1'b0;
            mode_change_r <= 1'b0;
        end else begin
            mode_r        <= next_mode_s;
            asp_r         <= (next_mode_s == MODE_ASP);
            got_r         <= (next_mode_s == MODE_GOT);
            adb_r         <= sadb_s && (next_mode_s == MODE_ASP);
            conflict_r    <= (next_mode_s == MODE_CONFLICT);
            mode_change_r <= (next_mode_s != mode_r);
        end
    end

    assign mode        = mode_r;
    assign asp         = asp_r;
    assign got         = got_r;
    assign adb         = adb_r;
    assign conflict    = conflict_r;
    assign mode_change = mode_change_r;

endmodule

// File: tb/tb_irrigation_input_conditioner.sv
// Scoreboard bench for irrigation_input_conditioner: a window-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares. Honours IRRIG_DEBOUNCE_BYPASS_EN.
module tb_irrigation_input_conditioner;

    localparam int PRESCALE  = 4;
    localparam int DEB_TICKS = 3;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       asp_raw = 1'b0;
    logic       got_raw = 1'b0;
    logic       adb_raw = 1'b0;
    logic       asp;
    logic       got;
    logic       adb;
    logic [1:0] mode;
    logic       conflict;
    logic       mode_change;

    irrigation_input_conditioner #(
        .PRESCALE  (PRESCALE),
        .DEB_TICKS (DEB_TICKS),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .asp_raw    (asp_raw),
        .got_raw    (got_raw),
        .adb_raw    (adb_raw),
        .asp        (asp),
        .got        (got),
        .adb        (adb),
        .mode       (mode),
        .conflict   (conflict),
        .mode_change(mode_change)
    );

    always #5 clock = ~clock;

    // Expected {mode, asp, got, adb, conflict, mode_change} after each clock edge.
    logic [6:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: raw samples are {asp, got, adb}.
    logic [2:0]           m_raw_d1;
    logic [2:0]           m_raw_d2;
    int                   m_ncyc;
    logic [2:0]           m_s;
    logic [1:0]           m_mode;
    logic [DEB_TICKS-1:0] m_hist [3];
    int                   m_hn   [3];

    function automatic logic [1:0] mode_rule(input logic [1:0] cur, input logic sa, input logic sg);
        case (cur)
            2'd0:    return (sa && sg) ? 2'd3 : (sa ? 2'd1 : (sg ? 2'd2 : 2'd0));
            2'd1:    return sg ? 2'd3 : (sa ? 2'd1 : 2'd0);
            2'd2:    return sa ? 2'd3 : (sg ? 2'd2 : 2'd0);
            default: return (!sa && !sg) ? 2'd0 : 2'd3;
        endcase
    endfunction

    task automatic model_step();
        logic [1:0] nm;
        logic [2:0] lvl;
        logic [2:0] s_used;
        if (reset) begin
            m_raw_d1 = 3'b111;
            m_raw_d2 = 3'b111;
            m_ncyc   = 0;
            m_s      = 3'b000;
            m_mode   = 2'd0;
            for (int c = 0; c < 3; c++) begin
                m_hist[c] = '0;
                m_hn[c]   = 0;
            end
            exp_q.push_back(7'b0);
            return;
        end
        lvl = ~m_raw_d2;
`ifdef IRRIG_DEBOUNCE_BYPASS_EN
        s_used = lvl;
`else
        s_used = m_s;
`endif
        nm = mode_rule(m_mode, s_used[2], s_used[1]);
        exp_q.push_back({nm, nm == 2'd1, nm == 2'd2, s_used[0] && (nm == 2'd1), nm == 2'd3, nm != m_mode});
        m_mode = nm;
`ifndef IRRIG_DEBOUNCE_BYPASS_EN
        // Level flips when the last DEB_TICKS tick samples all disagree with it.
        if ((m_ncyc % PRESCALE) == PRESCALE - 1) begin
            for (int c = 0; c < 3; c++) begin
                m_hist[c] = {m_hist[c][DEB_TICKS-2:0], lvl[c]};
                if (m_hn[c] < DEB_TICKS) m_hn[c]++;
                if (m_hn[c] == DEB_TICKS && m_hist[c] == {DEB_TICKS{~m_s[c]}}) begin
                    m_s[c]  = lvl[c];
                    m_hn[c] = 0;
                end
            end
        end
`endif
        m_raw_d2 = m_raw_d1;
        m_raw_d1 = {asp_raw, got_raw, adb_raw};
        m_ncyc++;
    endtask

    task automatic run(input logic r, input logic a, input logic g, input logic d, input int n);
        for (int i = 0; i < n; i++) begin
            reset   = r;
            asp_raw = a;
            got_raw = g;
            adb_raw = d;
            @(posedge clock);
            model_step();
            #1;
        end
    endtask

    // Monitor: outputs are presented every cycle, compare against the oldest prediction.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [6:0] e;
            logic [6:0] a;
            e = exp_q.pop_front();
            a = {mode, asp, got, adb, conflict, mode_change};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL outputs t=%0t {mode,asp,got,adb,conflict,chg} actual=%b expected=%b", $time, a, e);
        end
    end

    initial begin
        logic a;
        logic g;
        logic d;
        // Reset with all switches active, then hold briefly and release.
        run(1'b1, 1'b0, 1'b0, 1'b0, 3);
        run(1'b0, 1'b0, 1'b0, 1'b0, 5);
        run(1'b0, 1'b1, 1'b1, 1'b1, 30);
        // asp qualifies into ASP.
        run(1'b0, 1'b0, 1'b1, 1'b1, 30);
        // Short got glitch is rejected.
        run(1'b0, 1'b0, 1'b0, 1'b1, 7);
        run(1'b0, 1'b0, 1'b1, 1'b1, 30);
        // got qualifies -> CONFLICT, release asp -> stays, release got -> IDLE.
        run(1'b0, 1'b0, 1'b0, 1'b1, 30);
        run(1'b0, 1'b1, 1'b0, 1'b1, 30);
        run(1'b0, 1'b1, 1'b1, 1'b1, 30);
        // adb masked in GOT, passes once in ASP.
        run(1'b0, 1'b1, 1'b0, 1'b0, 30);
        run(1'b0, 1'b1, 1'b1, 1'b0, 30);
        run(1'b0, 1'b0, 1'b1, 1'b0, 30);
        run(1'b0, 1'b1, 1'b1, 1'b1, 30);
        // Reset just before asp would qualify discards progress.
        run(1'b0, 1'b0, 1'b1, 1'b1, 12);
        run(1'b1, 1'b0, 1'b1, 1'b1, 1);
        run(1'b0, 1'b0, 1'b1, 1'b1, 30);
        run(1'b0, 1'b1, 1'b1, 1'b1, 30);
        // Randomized switch activity with occasional resets.
        a = 1'b1;
        g = 1'b1;
        d = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       a = ~a;
                    1:       g = ~g;
                    default: d = ~d;
                endcase
            end
            run(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, a, g, d, 1);
        end
        run(1'b0, 1'b1, 1'b1, 1'b1, 2);
        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain leftover=%0d expected=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
